// File: rtl/op5_div_seq.sv
// Sequential restoring divider for the scalar ALU, one quotient bit per cycle.
// Start/busy/done handshake; results held until the next divide completes.
module op5_div_seq #(
  parameter bit SIGNED = 1'b1,
  parameter int DW     = 8,
  parameter int OPW    = 12
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [OPW-1:0] op_1,
  input  logic [OPW-1:0] op_2,
  output logic           busy,
  output logic           done,
  output logic           div_by_zero,
  output logic [OPW-1:0] result,
  output logic [OPW-1:0] remainder
);

  localparam int CW = $clog2(DW);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIV,
    S_SIGN,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] r_q, r_d;
  logic [DW-1:0] q_q, q_d;
  logic [DW-1:0] b_q, b_d;
  logic          sa_q, sa_d;
  logic          sb_q, sb_d;
  logic [DW-1:0] res_q, res_d;
  logic [DW-1:0] rem_q, rem_d;
  logic          dbz_q, dbz_d;

  logic [DW-1:0] a_in, b_in;
  logic          sa_in, sb_in;
  logic [DW:0]   r_sh, r_sub;
  logic          unused_bits;

  assign a_in  = op_1[DW-1:0];
  assign b_in  = op_2[DW-1:0];
  assign sa_in = a_in[DW-1] & SIGNED;
  assign sb_in = b_in[DW-1] & SIGNED;

  // Settled R is below |B|, so only the shifted value needs the extra bit.
  assign r_sh  = {r_q, q_q[DW-1]};
  assign r_sub = r_sh - {1'b0, b_q};

  assign unused_bits = ^{op_1[OPW-1:DW], op_2[OPW-1:DW], r_sub[DW]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    q_d     = q_q;
    b_d     = b_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    res_d   = res_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_DIV;
          sa_d    = sa_in;
          sb_d    = sb_in;
          q_d     = sa_in ? -a_in : a_in;
          b_d     = sb_in ? -b_in : b_in;
          r_d     = '0;
          cnt_d   = '0;
        end
      end
      S_DIV: begin
        q_d = {q_q[DW-2:0], 1'b0};
        r_d = r_sh[DW-1:0];
        if (r_sh >= {1'b0, b_q}) begin
          r_d    = r_sub[DW-1:0];
          q_d[0] = 1'b1;
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(DW - 1)) begin
          state_d = S_SIGN;
        end
      end
      S_SIGN: begin
        // A zero divisor leaves R = |A|, so the remainder path restores A.
        dbz_d = (b_q == '0);
        if (b_q == '0) begin
          res_d = '1;
        end else begin
          res_d = (sa_q ^ sb_q) ? -q_q : q_q;
        end
        rem_d   = sa_q ? -r_q : r_q;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      b_q     <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      res_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      q_q     <= q_d;
      b_q     <= b_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      res_q   <= res_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q == S_DIV) || (state_q == S_SIGN);
  assign done        = (state_q == S_DONE);
  assign div_by_zero = dbz_q;
  assign result      = {{(OPW-DW){1'b0}}, res_q};
  assign remainder   = {{(OPW-DW){1'b0}}, rem_q};

endmodule

// File: tb/tb_op5_div_seq.sv
// Randomized bench for op5_div_seq: signed and unsigned instances side by side,
// checked against integer-arithmetic reference models.
module tb_op5_div_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [11:0] op_1, op_2;

  logic        busy_s, done_s, dbz_s;
  logic [11:0] res_s, rem_s;
  logic        busy_u, done_u, dbz_u;
  logic [11:0] res_u, rem_u;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  op5_div_seq #(.SIGNED(1'b1), .DW(8), .OPW(12)) dut_s (
    .clk(clk), .rst(rst), .start(start),
    .op_1(op_1), .op_2(op_2),
    .busy(busy_s), .done(done_s), .div_by_zero(dbz_s),
    .result(res_s), .remainder(rem_s)
  );

  op5_div_seq #(.SIGNED(1'b0), .DW(8), .OPW(12)) dut_u (
    .clk(clk), .rst(rst), .start(start),
    .op_1(op_1), .op_2(op_2),
    .busy(busy_u), .done(done_u), .div_by_zero(dbz_u),
    .result(res_u), .remainder(rem_u)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // {div_by_zero, quotient, remainder}
  function automatic logic [16:0] ref_s(input logic [7:0] a,
                                        input logic [7:0] b);
    int sa, sb, q, r;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sb == 0) begin
      q = 255;
      r = sa;
    end else if (sa == -128 && sb == -1) begin
      q = 128;
      r = 0;
    end else begin
      q = sa / sb;
      r = sa % sb;
    end
    return {(sb == 0), q[7:0], r[7:0]};
  endfunction

  function automatic logic [16:0] ref_u(input logic [7:0] a,
                                        input logic [7:0] b);
    int ua, ub, q, r;
    ua = int'(a);
    ub = int'(b);
    if (ub == 0) begin
      q = 255;
      r = ua;
    end else begin
      q = ua / ub;
      r = ua % ub;
    end
    return {(ub == 0), q[7:0], r[7:0]};
  endfunction

  task automatic check_idle_clear(input string tag);
    check({tag, " busy_s"}, busy_s, 0);
    check({tag, " busy_u"}, busy_u, 0);
    check({tag, " done_s"}, done_s, 0);
    check({tag, " res_s"}, res_s, 0);
    check({tag, " rem_s"}, rem_s, 0);
    check({tag, " dbz_s"}, dbz_s, 0);
    check({tag, " res_u"}, res_u, 0);
    check({tag, " rem_u"}, rem_u, 0);
  endtask

  // mode 0: plain; 1: start re-asserted mid-flight; 2: rst mid-flight
  task automatic do_div(input logic [11:0] a, input logic [11:0] b,
                        input int mode);
    logic [16:0] es, eu;
    logic        seen_done;
    es = ref_s(a[7:0], b[7:0]);
    eu = ref_u(a[7:0], b[7:0]);
    @(negedge clk);
    op_1  = a;
    op_2  = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    op_1  = 12'($urandom);
    op_2  = 12'($urandom);
    for (int j = 0; j < 9; j++) begin
      if (mode == 1 && j == 2) start = 1'b1;
      if (mode == 1 && j == 3) start = 1'b0;
      if (mode == 2 && j == 3) rst = 1'b1;
      @(posedge clk);
      #1;
      if (mode == 2 && j == 3) begin
        rst = 1'b0;
        check_idle_clear("midrst");
        seen_done = 1'b0;
        repeat (12) begin
          @(posedge clk);
          #1;
          seen_done = seen_done | done_s | done_u;
        end
        check("midrst no_done", seen_done, 0);
        return;
      end
      if (j < 8) begin
        check("busy_s", busy_s, 1);
        check("busy_u", busy_u, 1);
        check("done_s early", done_s, 0);
      end
    end
    check("done_s", done_s, 1);
    check("done_u", done_u, 1);
    check("busy_s at done", busy_s, 0);
    check("res_s", res_s, {4'h0, es[15:8]});
    check("rem_s", rem_s, {4'h0, es[7:0]});
    check("dbz_s", dbz_s, es[16]);
    check("res_u", res_u, {4'h0, eu[15:8]});
    check("rem_u", rem_u, {4'h0, eu[7:0]});
    check("dbz_u", dbz_u, eu[16]);
    @(posedge clk);
    #1;
    check("done_s pulse", done_s, 0);
    check("busy_s after", busy_s, 0);
    check("res_s held", res_s, {4'h0, es[15:8]});
  endtask

  logic [11:0] dir_a [12];
  logic [11:0] dir_b [12];

  initial begin
    dir_a = '{12'h064, 12'h09C, 12'h064, 12'h080, 12'h080, 12'h037,
              12'h009, 12'h0C8, 12'h0FF, 12'h080, 12'hA7F, 12'h000};
    dir_b = '{12'h007, 12'h007, 12'h0F9, 12'h0FF, 12'h003, 12'h000,
              12'h003, 12'h007, 12'h001, 12'h080, 12'h5F0, 12'h0FF};
    rst   = 1'b1;
    start = 1'b0;
    op_1  = '0;
    op_2  = '0;
    repeat (2) @(posedge clk);
    #1;
    check_idle_clear("reset");

    // rst must win over a simultaneous start
    op_1  = 12'h064;
    op_2  = 12'h007;
    start = 1'b1;
    @(posedge clk);
    #1;
    check_idle_clear("rst_vs_start");
    rst   = 1'b0;
    start = 1'b0;

    for (int i = 0; i < 12; i++) begin
      do_div(dir_a[i], dir_b[i], 0);
    end

    for (int i = 0; i < 60; i++) begin
      logic [11:0] ra, rb;
      ra = 12'($urandom);
      rb = 12'($urandom);
      if ($urandom_range(0, 7) == 0) rb[7:0] = 8'h00;
      if ($urandom_range(0, 7) == 0) ra[7:0] = 8'h80;
      do_div(ra, rb, 0);
    end

    do_div(12'h064, 12'h007, 1);
    do_div(12'h09C, 12'h0F9, 1);
    do_div(12'h037, 12'h000, 2);
    do_div(12'h009, 12'h003, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
